// File: rtl/icw_sequence_controller.sv
`default_nettype none
// ============================================================================
//  Module      : icw_sequence_controller
//  Description : Initialization command word (ICW1..ICW4) sequencer for an
//                8259-style interrupt controller. Captures the configuration
//                fields written during the init sequence, reports READY and
//                forwards odd-address writes made after init as OCW1 strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module icw_sequence_controller #(
   parameter int          NUM_IR           = 8,
   parameter logic [4:0]  ICW4_RESET_VALUE = 5'b00000
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              write_initial_command_word_1,
   input  logic              write_odd_address,
   input  logic [7:0]        internal_data_bus,

   // ICW1 fields
   output logic              level_or_edge_triggered_config,
   output logic              single_or_cascade_config,
   output logic              call_address_interval_4_or_8_config,

   // ICW2 field
   output logic [4:0]        interrupt_vector_address,

   // ICW3 field
   output logic [NUM_IR-1:0] cascade_device_config,

   // ICW4 fields
   output logic              special_fully_nest_config,
   output logic              buffered_mode_config,
   output logic              buffered_master_or_slave_config,
   output logic              auto_eoi_config,
   output logic              u8086_or_mcs80_config,

   // Post-init operation and status
   output logic              write_operation_control_word_1,
   output logic              initialization_done,
   output logic [2:0]        init_state
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_ICW2 = 3'd1;
   localparam logic [2:0] S_WAIT_ICW3 = 3'd2;
   localparam logic [2:0] S_WAIT_ICW4 = 3'd3;
   localparam logic [2:0] S_READY     = 3'd4;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [2:0]        r_state;
   logic              r_ltim;       // ICW1 D3
   logic              r_adi;        // ICW1 D2
   logic              r_sngl;       // ICW1 D1
   logic              r_ic4;        // ICW1 D0, decides whether ICW4 follows
   logic [4:0]        r_vector;     // ICW2 D7..D3
   logic [NUM_IR-1:0] r_cascade;    // ICW3
   logic [4:0]        r_icw4;       // {SFNM,BUF,M/S,AEOI,uPM}
   logic              r_ocw1;

   // ------------------------------------------------------------------------
   // Decoded write qualifiers. ICW1 always wins, so an odd write that
   // coincides with it is dropped here once for every consumer below.
   // ------------------------------------------------------------------------
   logic       w_odd_write;
   logic       w_wr_icw2;
   logic       w_wr_icw3;
   logic       w_wr_icw4;
   logic       w_wr_ocw1;
   logic [2:0] w_next_state;

   assign w_odd_write = write_odd_address & ~write_initial_command_word_1;
   assign w_wr_icw2   = w_odd_write & (r_state == S_WAIT_ICW2);
   assign w_wr_icw3   = w_odd_write & (r_state == S_WAIT_ICW3);
   assign w_wr_icw4   = w_odd_write & (r_state == S_WAIT_ICW4);
   assign w_wr_ocw1   = w_odd_write & (r_state == S_READY);

   // Next-state selection; ICW1 restarts the sequence from any state
   always_comb begin
      w_next_state = r_state;
      if (write_initial_command_word_1) begin
         w_next_state = S_WAIT_ICW2;
      end else if (write_odd_address) begin
         case (r_state)
            S_WAIT_ICW2: begin
               if (!r_sngl)
                  w_next_state = S_WAIT_ICW3;
               else if (r_ic4)
                  w_next_state = S_WAIT_ICW4;
               else
                  w_next_state = S_READY;
            end
            S_WAIT_ICW3: begin
               if (r_ic4)
                  w_next_state = S_WAIT_ICW4;
               else
                  w_next_state = S_READY;
            end
            S_WAIT_ICW4: w_next_state = S_READY;
            S_READY:     w_next_state = S_READY;
            S_IDLE:      w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   // ICW1 fields: only loaded by ICW1 itself
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ltim <= 1'b0;
         r_adi  <= 1'b0;
         r_sngl <= 1'b0;
         r_ic4  <= 1'b0;
      end else if (write_initial_command_word_1) begin
         r_ltim <= internal_data_bus[3];
         r_adi  <= internal_data_bus[2];
         r_sngl <= internal_data_bus[1];
         r_ic4  <= internal_data_bus[0];
      end
   end

   // ICW2 vector base: cleared by ICW1, loaded in WAIT_ICW2
   always_ff @(posedge clock) begin
      if (reset || write_initial_command_word_1)
         r_vector <= 5'd0;
      else if (w_wr_icw2)
         r_vector <= internal_data_bus[7:3];
   end

   // ICW3 cascade map: cleared by ICW1, loaded in WAIT_ICW3
   always_ff @(posedge clock) begin
      if (reset || write_initial_command_word_1)
         r_cascade <= '0;
      else if (w_wr_icw3)
         r_cascade <= internal_data_bus[NUM_IR-1:0];
   end

   // ICW4 mode bits: return to the reset value on ICW1, loaded in WAIT_ICW4
   always_ff @(posedge clock) begin
      if (reset || write_initial_command_word_1)
         r_icw4 <= ICW4_RESET_VALUE;
      else if (w_wr_icw4)
         r_icw4 <= internal_data_bus[4:0];
   end

   // OCW1 strobe: one cycle after an odd write accepted in READY
   always_ff @(posedge clock) begin
      if (reset)
         r_ocw1 <= 1'b0;
      else
         r_ocw1 <= w_wr_ocw1;
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign level_or_edge_triggered_config      = r_ltim;
   assign call_address_interval_4_or_8_config = r_adi;
   assign single_or_cascade_config            = r_sngl;

   assign interrupt_vector_address            = r_vector;
   assign cascade_device_config               = r_cascade;

   assign special_fully_nest_config           = r_icw4[4];
   assign buffered_mode_config                = r_icw4[3];
   assign buffered_master_or_slave_config     = r_icw4[2];
   assign auto_eoi_config                     = r_icw4[1];
   assign u8086_or_mcs80_config               = r_icw4[0];

   assign write_operation_control_word_1      = r_ocw1;
   assign initialization_done                 = (r_state == S_READY);
   assign init_state                          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_icw_sequence_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icw_sequence_controller
//  Description : Self-checking bench for icw_sequence_controller. Each step
//                pushes its expected output snapshot into a scoreboard queue
//                as it is driven; the snapshot is popped and compared once
//                the DUT has clocked the step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icw_sequence_controller;

   localparam int         NUM_IR = 8;
   localparam logic [4:0] RV     = 5'b01010;

   // Snapshot of every DUT output
   typedef struct packed {
      logic [2:0] state;
      logic       done;
      logic       ocw;
      logic [2:0] icw1;     // {LTIM, ADI, SNGL}
      logic [4:0] vec;
      logic [7:0] cas;
      logic [4:0] icw4;
   } snap_t;

   typedef struct packed {
      logic       i1;
      logic       od;
      logic       rs;
      logic [7:0] d;
      snap_t      e;
   } step_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_icw1;
   logic       wr_odd;
   logic [7:0] data;

   logic       ltim, sngl, adi;
   logic [4:0] vec;
   logic [7:0] cas;
   logic       sfnm, buff, ms, aeoi, upm;
   logic       ocw1, done;
   logic [2:0] state;

   int    errors = 0;
   int    checks = 0;
   snap_t sb[$];

   always #5 clk = ~clk;

   icw_sequence_controller #(
      .NUM_IR           (NUM_IR),
      .ICW4_RESET_VALUE (RV)
   ) dut (
      .clock                               (clk),
      .reset                               (reset),
      .write_initial_command_word_1        (wr_icw1),
      .write_odd_address                   (wr_odd),
      .internal_data_bus                   (data),
      .level_or_edge_triggered_config      (ltim),
      .single_or_cascade_config            (sngl),
      .call_address_interval_4_or_8_config (adi),
      .interrupt_vector_address            (vec),
      .cascade_device_config               (cas),
      .special_fully_nest_config           (sfnm),
      .buffered_mode_config                (buff),
      .buffered_master_or_slave_config     (ms),
      .auto_eoi_config                     (aeoi),
      .u8086_or_mcs80_config               (upm),
      .write_operation_control_word_1      (ocw1),
      .initialization_done                 (done),
      .init_state                          (state)
   );

   function automatic snap_t mk(input logic [2:0] s, input logic dn, input logic oc,
                                input logic [2:0] c1, input logic [4:0] v,
                                input logic [7:0] c, input logic [4:0] c4);
      snap_t r;
      r.state = s; r.done = dn; r.ocw = oc; r.icw1 = c1;
      r.vec = v; r.cas = c; r.icw4 = c4;
      return r;
   endfunction

   function automatic step_t st(input logic i1, input logic od, input logic rs,
                                input logic [7:0] d, input snap_t e);
      step_t r;
      r.i1 = i1; r.od = od; r.rs = rs; r.d = d; r.e = e;
      return r;
   endfunction

   function automatic snap_t observe();
      return mk(state, done, ocw1, {ltim, adi, sngl}, vec, cas,
                {sfnm, buff, ms, aeoi, upm});
   endfunction

   // Drive one step for one clock, record its expectation in the scoreboard
   task automatic apply(input step_t s);
      @(negedge clk);
      wr_icw1 = s.i1;
      wr_odd  = s.od;
      reset   = s.rs;
      data    = s.d;
      sb.push_back(s.e);
      @(posedge clk);
      #1;
      wr_icw1 = 1'b0;
      wr_odd  = 1'b0;
      reset   = 1'b0;
      data    = 8'h00;
   endtask

   task automatic test_reset();
      step_t q[$];
      snap_t o, e;
      q.push_back(st(0, 0, 1, 8'h00, mk(0, 0, 0, 3'b000, 5'd0, 8'h00, RV)));
      q.push_back(st(1, 1, 1, 8'hFF, mk(0, 0, 0, 3'b000, 5'd0, 8'h00, RV)));
      q.push_back(st(0, 0, 0, 8'h00, mk(0, 0, 0, 3'b000, 5'd0, 8'h00, RV)));
      foreach (q[i]) begin
         apply(q[i]);
         o = observe();
         e = sb.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset step%0d got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_single_no_icw4();
      step_t q[$];
      snap_t o, e;
      q.push_back(st(1, 0, 0, 8'h12, mk(1, 0, 0, 3'b001, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'h48, mk(4, 1, 0, 3'b001, 5'b01001, 8'h00, RV)));
      q.push_back(st(0, 0, 0, 8'h00, mk(4, 1, 0, 3'b001, 5'b01001, 8'h00, RV)));
      foreach (q[i]) begin
         apply(q[i]);
         o = observe();
         e = sb.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL single step%0d got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_cascade_icw4();
      step_t q[$];
      snap_t o, e;
      q.push_back(st(1, 0, 0, 8'h11, mk(1, 0, 0, 3'b000, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 0, 0, 8'h00, mk(1, 0, 0, 3'b000, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'h20, mk(2, 0, 0, 3'b000, 5'b00100, 8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'h84, mk(3, 0, 0, 3'b000, 5'b00100, 8'h84, RV)));
      q.push_back(st(0, 1, 0, 8'h1F, mk(4, 1, 0, 3'b000, 5'b00100, 8'h84, 5'h1F)));
      q.push_back(st(0, 0, 0, 8'h00, mk(4, 1, 0, 3'b000, 5'b00100, 8'h84, 5'h1F)));
      foreach (q[i]) begin
         apply(q[i]);
         o = observe();
         e = sb.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL cascade step%0d got %h want %h", i, o, e);
         end
      end
   endtask

   // Continues from the cascade run: re-init, then ICW1 colliding with ICW4
   task automatic test_reinit_and_simultaneous();
      step_t q[$];
      snap_t o, e;
      q.push_back(st(1, 0, 0, 8'h13, mk(1, 0, 0, 3'b001, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'h08, mk(3, 0, 0, 3'b001, 5'b00001, 8'h00, RV)));
      q.push_back(st(1, 1, 0, 8'h1F, mk(1, 0, 0, 3'b111, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 0, 0, 8'h00, mk(1, 0, 0, 3'b111, 5'd0,     8'h00, RV)));
      foreach (q[i]) begin
         apply(q[i]);
         o = observe();
         e = sb.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reinit_simul step%0d got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_back_to_back_ocw1();
      step_t q[$];
      snap_t o, e;
      q.push_back(st(1, 0, 0, 8'h16, mk(1, 0, 0, 3'b011, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'h48, mk(4, 1, 0, 3'b011, 5'b01001, 8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'hAA, mk(4, 1, 1, 3'b011, 5'b01001, 8'h00, RV)));
      q.push_back(st(0, 0, 0, 8'h00, mk(4, 1, 0, 3'b011, 5'b01001, 8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'h55, mk(4, 1, 1, 3'b011, 5'b01001, 8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'hF0, mk(4, 1, 1, 3'b011, 5'b01001, 8'h00, RV)));
      q.push_back(st(1, 1, 0, 8'h10, mk(1, 0, 0, 3'b000, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 0, 1, 8'h00, mk(0, 0, 0, 3'b000, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'hAA, mk(0, 0, 0, 3'b000, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 0, 0, 8'h00, mk(0, 0, 0, 3'b000, 5'd0,     8'h00, RV)));
      foreach (q[i]) begin
         apply(q[i]);
         o = observe();
         e = sb.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL ocw1 step%0d got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_reset_mid_sequence();
      step_t q[$];
      snap_t o, e;
      q.push_back(st(1, 0, 0, 8'h1C, mk(1, 0, 0, 3'b110, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'h50, mk(2, 0, 0, 3'b110, 5'b01010, 8'h00, RV)));
      q.push_back(st(0, 1, 1, 8'h84, mk(0, 0, 0, 3'b000, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'h84, mk(0, 0, 0, 3'b000, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 0, 0, 8'h00, mk(0, 0, 0, 3'b000, 5'd0,     8'h00, RV)));
      foreach (q[i]) begin
         apply(q[i]);
         o = observe();
         e = sb.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_mid step%0d got %h want %h", i, o, e);
         end
      end
   endtask

   // Cascade without ICW4: WAIT_ICW3 goes straight to READY
   task automatic test_cascade_no_icw4();
      step_t q[$];
      snap_t o, e;
      q.push_back(st(1, 0, 0, 8'h14, mk(1, 0, 0, 3'b010, 5'd0,     8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'hF8, mk(2, 0, 0, 3'b010, 5'b11111, 8'h00, RV)));
      q.push_back(st(0, 1, 0, 8'h03, mk(4, 1, 0, 3'b010, 5'b11111, 8'h03, RV)));
      foreach (q[i]) begin
         apply(q[i]);
         o = observe();
         e = sb.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL cascade_no_icw4 step%0d got %h want %h", i, o, e);
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      wr_icw1 = 1'b0;
      wr_odd  = 1'b0;
      data    = 8'h00;
      test_reset();
      test_single_no_icw4();
      test_cascade_icw4();
      test_reinit_and_simultaneous();
      test_back_to_back_ocw1();
      test_reset_mid_sequence();
      test_cascade_no_icw4();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/icw_sequence_controller.md
ICW_SEQUENCE_CONTROLLER -- requirements
Module: icw_sequence_controller

Interface
REQ-001 SHALL have parameter NUM_IR, default 8, meaning the number of interrupt request lines and the width of the ICW3 cascade field (legal 1..8).
REQ-002 SHALL have parameter ICW4_RESET_VALUE, default 5'b00000, meaning the ICW4 bits {SFNM,BUF,M/S,AEOI,uPM} loaded on reset and on ICW1.
REQ-003 SHALL have port clock  input  1  system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port write_initial_command_word_1  input  1  one-cycle strobe: write with A0=0, D4=1.
REQ-006 SHALL have port write_odd_address  input  1  one-cycle strobe: any write with A0=1.
REQ-007 SHALL have port internal_data_bus  input  8  write data, sampled when a strobe is high.
REQ-008 SHALL have ports level_or_edge_triggered_config, single_or_cascade_config, call_address_interval_4_or_8_config  output  1 each  ICW1 D3, D1, D2.
REQ-009 SHALL have port interrupt_vector_address  output  5  ICW2 D7..D3.
REQ-010 SHALL have port cascade_device_config  output  NUM_IR  ICW3 D[NUM_IR-1:0].
REQ-011 SHALL have ports special_fully_nest_config, buffered_mode_config, buffered_master_or_slave_config, auto_eoi_config, u8086_or_mcs80_config  output  1 each  ICW4 D4..D0.
REQ-012 SHALL have port write_operation_control_word_1  output  1  one-cycle strobe forwarding an A0=1 write that occurs in READY (OCW1).
REQ-013 SHALL have port initialization_done  output  1  high only in state READY.
REQ-014 SHALL have port init_state  output  3  current state encoding for debug.

Function
REQ-015 SHALL implement states IDLE=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4, registered.
REQ-016 SHALL, on write_initial_command_word_1 in any state: latch ICW1 D3/D2/D1 and IC4 (D0), clear ICW2/ICW3 fields to 0, load ICW4 fields from ICW4_RESET_VALUE, go to WAIT_ICW2.
REQ-017 SHALL, on write_odd_address in WAIT_ICW2: latch D7..D3 into interrupt_vector_address; next state WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else READY.
REQ-018 SHALL, on write_odd_address in WAIT_ICW3: latch cascade_device_config; next state WAIT_ICW4 if IC4=1, else READY.
REQ-019 SHALL, on write_odd_address in WAIT_ICW4: latch D4..D0 into the five ICW4 outputs; next state READY.
REQ-020 SHALL, on write_odd_address in READY: pulse write_operation_control_word_1 for exactly the following cycle (1-cycle latency), with no config change.
REQ-021 SHALL ignore write_odd_address in IDLE (no state or output change, no OCW1 strobe).
REQ-022 SHALL give write_initial_command_word_1 priority when both strobes are high in one cycle; the odd write is discarded.
REQ-023 SHALL make all config outputs registered; new values visible the cycle after the strobe.
REQ-024 SHALL hold all fields stable while no strobe is high.

Reset
REQ-025 SHALL, with reset high at a rising edge, force state IDLE, all ICW1/ICW2/ICW3 outputs 0, ICW4 outputs to ICW4_RESET_VALUE, write_operation_control_word_1 0, initialization_done 0.
REQ-026 SHALL give reset priority over both strobes, including mid-sequence (any WAIT state returns to IDLE).

Verification
REQ-027 Single, no ICW4: ICW1=0x12, odd 0x48 -> vector 5'b01001, state READY two writes later, ICW4 outputs = reset value, done=1.
REQ-028 Cascade with ICW4: ICW1=0x11, ICW2=0x20, ICW3=0x84, ICW4=0x1F -> cascade_device_config=0x84, all five ICW4 outputs 1, passes states 1->2->3->4.
REQ-029 Re-init: after REQ-028, ICW1=0x13 -> ICW4 outputs back to reset value, vector 0, cascade 0, done=0, state 1.
REQ-030 Simultaneous: in WAIT_ICW4 assert both strobes with data 0x1F -> ICW4 outputs unchanged from reset value, state WAIT_ICW2.
REQ-031 OCW1 pass-through: in READY, odd write 0xAA -> write_operation_control_word_1 high exactly one cycle, no config change; in IDLE, odd write -> no strobe.
REQ-032 Reset mid-sequence: in WAIT_ICW3 assert reset -> state 0, all outputs at reset values next cycle; following odd write ignored.
